pcs_block_gen_multilane: RTL
============================

Name: pcs_block_gen_multilane

Overview:
Multi-lane 64b/66b traffic generator for the Ethernet PCS generator/checker test path. A single shared packet state machine drives N_LANES lanes in lockstep: Idle gaps, then Start, Data and Terminate blocks. Each lane carries its own PRBS31 payload and has an optional self-synchronising scrambler. It adds per-block valid/ready backpressure, a graceful stop, error injection and a packet counter. The output feeds the transcoder/checker stage directly.

Parameters:
N_LANES, 8, number of parallel 66b lanes
NB_BLOCK, 66, block width: 2-bit sync header plus 64-bit payload
NB_LEN, 16, width of packet-length and IPG configuration inputs
NB_CNT, 32, packet counter width
PRBS_SEED, 31'h7FFF_FFFF, PRBS31 seed for lane 0; lane k uses PRBS_SEED ^ k (must be nonzero)
SCR_SEED, 58'h3FF_FFFF_FFFF_FFFF, scrambler reset state, identical for all lanes

Ports:
clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_enable  in  1  start/continue generation; deassertion causes a graceful stop
i_pkt_len  in  NB_LEN  number of Data blocks between Start and Terminate
i_ipg  in  NB_LEN  Idle blocks between packets; 0 is treated as 1
i_scr_en  in  1  enables the payload scrambler
i_err_inject  in  1  single-cycle pulse that arms an error on the next Data block
i_err_lane  in  $clog2(N_LANES)  lane that receives the injected error
i_err_hdr  in  1  error type: 1 = header forced to 2'b00; 0 = payload bit 0 flipped
i_ready  in  1  downstream accepts the current beat
o_blocks  out  N_LANES*NB_BLOCK  lane k occupies bits [k*66 +: 66]; header at [1:0], payload at [65:2]
o_valid  out  1  o_blocks is valid
o_busy  out  1  FSM is not in STOP
o_pkt_cnt  out  NB_CNT  count of accepted Terminate beats; wraps

Behaviour:
- Reset values: o_blocks=0, o_valid=0, o_busy=0, o_pkt_cnt=0, FSM=STOP, error not armed, PRBS and scrambler states at their seeds.
- Reset applied mid-operation has the same effect, on the next edge.
- Output is a registered beat. A new beat loads when (!o_valid || i_ready). While o_valid && !i_ready, o_blocks and all state hold unchanged.
- Accept = o_valid && i_ready.
- Headers: Data = 2'b01, Control = 2'b10. Payload byte 0 = payload[7:0] and is transmitted first.
- Block contents:
  - Idle: type 0x1E, then eight 7-bit idle codes of 0x00.
  - Start: type 0x78, then PRBS bits [55:0].
  - Data: 64 PRBS bits.
  - Terminate: type 0x87, then 0x00 for the rest of the block.
- PRBS31 (x^31+x^28+1) is per lane and advances by 64 bits only on an accepted Start or Data beat.
- Scrambler (x^58+x^39+1) is per lane:
  - Applies to all 64 payload bits of every block, never to the header.
  - State advances only on an accepted beat while i_scr_en=1.
  - With i_scr_en=0, payload passes unscrambled and state holds.
- FSM (transitions occur on accept, except from STOP):
  - STOP: o_valid=0. If i_enable=1, load an Idle beat the next cycle, set o_valid=1, go to IDLE, and load the gap counter with max(i_ipg,1).
  - IDLE: emit Idle and decrement the gap counter on each accept. At 0: if i_enable, go to START; otherwise go to STOP (o_valid falls on the cycle after the last accepted Idle).
  - START: sample i_pkt_len into the length counter. Go to DATA, or go to TERM if the sampled length is 0.
  - DATA: decrement on each accept; go to TERM after i_pkt_len accepted Data beats.
  - TERM: increment o_pkt_cnt on accept; return to IDLE and reload the gap from i_ipg.
- i_enable deasserted mid-packet: the packet completes (DATA→TERM→IDLE gap), then the FSM goes to STOP. No truncated packets are ever produced.
- i_pkt_len and i_ipg changes take effect only at the next START or IDLE entry.
- Error injection:
  - The i_err_inject pulse latches the arm, i_err_lane and i_err_hdr.
  - The error applies to the next Data-beat load on that lane only, then the arm clears.
  - A payload flip is applied after scrambling.
  - A pulse that arrives while already armed is ignored.
- All lanes share one header/type sequence. Only payload bits differ per lane.

Test Plan:
- Reset, then i_enable=1, i_pkt_len=3, i_ipg=2, i_ready=1, i_scr_en=0 -> sequence on every lane: Idle, Idle, Start, Data×3, Term, Idle×2, ... Lane 0 Start payload[7:0]=0x78. o_pkt_cnt=1 after the first Term.
- Same setup with i_ready toggling 1,0,0,1 per cycle -> o_blocks stable while stalled; the accepted beat sequence matches the full-rate capture exactly.
- i_enable dropped during the 2nd Data beat of i_pkt_len=5 -> remaining Data and Term still emitted, then the Idle gap, then o_valid=0 and o_busy=0. No Start appears after the drop.
- i_scr_en=1, 10 packets captured -> software descrambler with SCR_SEED recovers PRBS31 data matching the i_scr_en=0 run. Lanes 0 and 1 payloads differ.
- i_err_inject with i_err_lane=3, i_err_hdr=1 -> exactly one Data block on lane 3 has header 2'b00; all other lanes are unaffected. Repeat with i_err_hdr=0 -> payload bit 0 differs from the golden model in exactly one block.
- i_pkt_len=0, i_ipg=0 -> Start, Term, Idle, Start, ... (gap of 1). i_rst asserted mid-packet -> next cycle all outputs are 0 and FSM=STOP.

Source files
------------

// File: rtl/pcs_block_gen_multilane.sv
// rtl/pcs_block_gen_multilane.sv - multi-lane 64b/66b Idle/Start/Data/Terminate traffic generator
//
// Purpose:
//   One packet FSM drives N_LANES 66b lanes in lockstep: an Idle gap, then
//   Start, i_pkt_len Data blocks and Terminate. Every lane has its own PRBS31
//   payload source and an optional self-synchronising x^58+x^39+1 scrambler.
//   The output is a registered beat with valid/ready handshaking.
//
// Ports:
//   clk, i_rst        clock, synchronous active-high reset
//   i_enable          run request; dropping it finishes the current packet and gap
//   i_pkt_len, i_ipg  Data blocks per packet, Idle blocks between packets (0 -> 1)
//   i_scr_en          scramble all 64 payload bits of every block
//   i_err_inject      pulse that arms one error on the next Data block
//   i_err_lane        lane that takes the error
//   i_err_hdr         1: header forced to 2'b00, 0: payload bit 0 inverted
//   i_ready           downstream accepts the current beat
//   o_blocks          lane k at [k*66 +: 66], header [1:0], payload [65:2]
//   o_valid           o_blocks holds a beat
//   o_busy            FSM is not stopped
//   o_pkt_cnt         accepted Terminate beats, wrapping

module pcs_block_gen_multilane #(
    parameter int          N_LANES   = 8,
    parameter int          NB_BLOCK  = 66,
    parameter int          NB_LEN    = 16,
    parameter int          NB_CNT    = 32,
    parameter logic [30:0] PRBS_SEED = 31'h7FFF_FFFF,
    parameter logic [57:0] SCR_SEED  = 58'h3FF_FFFF_FFFF_FFFF
) (
    input  logic                        clk,
    input  logic                        i_rst,
    input  logic                        i_enable,
    input  logic [NB_LEN-1:0]           i_pkt_len,
    input  logic [NB_LEN-1:0]           i_ipg,
    input  logic                        i_scr_en,
    input  logic                        i_err_inject,
    input  logic [$clog2(N_LANES)-1:0]  i_err_lane,
    input  logic                        i_err_hdr,
    input  logic                        i_ready,
    output logic [N_LANES*NB_BLOCK-1:0] o_blocks,
    output logic                        o_valid,
    output logic                        o_busy,
    output logic [NB_CNT-1:0]           o_pkt_cnt
);

    localparam int         LW       = $clog2(N_LANES);
    localparam logic [1:0] HDR_DATA = 2'b01;
    localparam logic [1:0] HDR_CTRL = 2'b10;

    typedef enum logic [2:0] {
        ST_STOP,
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_TERM
    } state_t;

    // The state names the kind of beat currently held in the output register.
    state_t                      state_q, state_d;
    logic [NB_LEN-1:0]           gap_q, gap_d;
    logic [NB_LEN-1:0]           len_q, len_d;
    logic [NB_CNT-1:0]           cnt_q, cnt_d;
    logic                        valid_q, valid_d;
    logic [N_LANES*NB_BLOCK-1:0] blocks_q, blocks_d;
    logic                        arm_q, arm_d;
    logic [LW-1:0]               err_lane_q, err_lane_d;
    logic                        err_hdr_q, err_hdr_d;
    logic [30:0]                 prbs_q [N_LANES];
    logic [30:0]                 prbs_d [N_LANES];
    logic [57:0]                 scr_q  [N_LANES];
    logic [57:0]                 scr_d  [N_LANES];

    logic                        accept;
    logic                        gen;
    state_t                      nxt;
    logic [NB_LEN-1:0]           ipg_eff;
    logic [63:0]                 word;
    logic [63:0]                 plain;
    logic [63:0]                 pay;
    logic [1:0]                  hdr;
    logic                        err_hit;

    // 64 serial PRBS31 bits; bit 0 is generated (and transmitted) first.
    function automatic logic [63:0] prbs_word(input logic [30:0] seed);
        logic [30:0] s;
        logic [63:0] w;
        logic        b;
        s = seed;
        w = '0;
        for (int i = 0; i < 64; i++) begin
            b    = s[30] ^ s[27];
            w[i] = b;
            s    = {s[29:0], b};
        end
        return w;
    endfunction

    function automatic logic [30:0] prbs_adv(input logic [30:0] seed);
        logic [30:0] s;
        logic        b;
        s = seed;
        for (int i = 0; i < 64; i++) begin
            b = s[30] ^ s[27];
            s = {s[29:0], b};
        end
        return s;
    endfunction

    // s[0] holds the most recent scrambled bit, s[57] the oldest.
    function automatic logic [63:0] scramble(input logic [57:0] seed, input logic [63:0] x);
        logic [57:0] s;
        logic [63:0] y;
        s = seed;
        y = '0;
        for (int i = 0; i < 64; i++) begin
            y[i] = x[i] ^ s[38] ^ s[57];
            s    = {s[56:0], y[i]};
        end
        return y;
    endfunction

    // After 64 bits the self-synchronising state is just the last 58 scrambled
    // bits, so it is recovered from the beat being accepted (y[63:6]). Bit 0 is
    // outside that window, which keeps an injected payload flip out of the state.
    function automatic logic [57:0] scr_after(input logic [57:0] y_hi);
        logic [57:0] s;
        for (int m = 0; m < 58; m++) begin
            s[m] = y_hi[57-m];
        end
        return s;
    endfunction

    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        valid_d    = valid_q;
        blocks_d   = blocks_q;
        arm_d      = arm_q;
        err_lane_d = err_lane_q;
        err_hdr_d  = err_hdr_q;
        gen        = 1'b0;
        nxt        = ST_IDLE;
        word       = '0;
        plain      = '0;
        pay        = '0;
        hdr        = HDR_CTRL;
        err_hit    = 1'b0;
        accept     = valid_q && i_ready;
        ipg_eff    = (i_ipg == '0) ? NB_LEN'(1) : i_ipg;

        // Sequence state moves on the accept edge, and the beat loaded on that
        // same edge is built from the advanced values.
        for (int k = 0; k < N_LANES; k++) begin
            prbs_d[k] = prbs_q[k];
            scr_d[k]  = scr_q[k];
            if (accept && (state_q == ST_START || state_q == ST_DATA)) begin
                prbs_d[k] = prbs_adv(prbs_q[k]);
            end
            if (accept && i_scr_en) begin
                scr_d[k] = scr_after(blocks_q[k*NB_BLOCK+8 +: 58]);
            end
        end

        case (state_q)
            ST_STOP: begin
                if (i_enable) begin
                    gen   = 1'b1;
                    nxt   = ST_IDLE;
                    gap_d = ipg_eff;
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    gap_d = gap_q - NB_LEN'(1);
                    if (gap_q == NB_LEN'(1)) begin
                        if (i_enable) begin
                            gen   = 1'b1;
                            nxt   = ST_START;
                            len_d = i_pkt_len;
                        end else begin
                            state_d = ST_STOP;
                            valid_d = 1'b0;
                        end
                    end else begin
                        gen = 1'b1;
                        nxt = ST_IDLE;
                    end
                end
            end
            ST_START: begin
                if (accept) begin
                    gen = 1'b1;
                    nxt = (len_q == '0) ? ST_TERM : ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    gen   = 1'b1;
                    len_d = len_q - NB_LEN'(1);
                    nxt   = (len_q == NB_LEN'(1)) ? ST_TERM : ST_DATA;
                end
            end
            ST_TERM: begin
                if (accept) begin
                    gen   = 1'b1;
                    nxt   = ST_IDLE;
                    cnt_d = cnt_q + NB_CNT'(1);
                    gap_d = ipg_eff;
                end
            end
            default: begin
                state_d = ST_STOP;
                valid_d = 1'b0;
            end
        endcase

        if (gen) begin
            state_d = nxt;
            valid_d = 1'b1;
            for (int k = 0; k < N_LANES; k++) begin
                word = prbs_word(prbs_d[k]);
                case (nxt)
                    ST_START: begin
                        plain = {word[55:0], 8'h78};
                        hdr   = HDR_CTRL;
                    end
                    ST_DATA: begin
                        plain = word;
                        hdr   = HDR_DATA;
                    end
                    ST_TERM: begin
                        plain = {56'h0, 8'h87};
                        hdr   = HDR_CTRL;
                    end
                    default: begin
                        plain = {56'h0, 8'h1E};
                        hdr   = HDR_CTRL;
                    end
                endcase
                pay     = i_scr_en ? scramble(scr_d[k], plain) : plain;
                err_hit = (nxt == ST_DATA) && arm_q && (err_lane_q == LW'(k));
                if (err_hit) begin
                    if (err_hdr_q) begin
                        hdr = 2'b00;
                    end else begin
                        pay[0] = ~pay[0];
                    end
                end
                blocks_d[k*NB_BLOCK +: NB_BLOCK] = {pay, hdr};
            end
        end

        // One error per arm; a pulse while armed is dropped.
        if (gen && nxt == ST_DATA && arm_q) begin
            arm_d = 1'b0;
        end else if (i_err_inject && !arm_q) begin
            arm_d      = 1'b1;
            err_lane_d = i_err_lane;
            err_hdr_d  = i_err_hdr;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q    <= ST_STOP;
            gap_q      <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            blocks_q   <= '0;
            arm_q      <= 1'b0;
            err_lane_q <= '0;
            err_hdr_q  <= 1'b0;
            for (int k = 0; k < N_LANES; k++) begin
                prbs_q[k] <= PRBS_SEED ^ 31'(k);
                scr_q[k]  <= SCR_SEED;
            end
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            blocks_q   <= blocks_d;
            arm_q      <= arm_d;
            err_lane_q <= err_lane_d;
            err_hdr_q  <= err_hdr_d;
            for (int k = 0; k < N_LANES; k++) begin
                prbs_q[k] <= prbs_d[k];
                scr_q[k]  <= scr_d[k];
            end
        end
    end

    assign o_blocks  = blocks_q;
    assign o_valid   = valid_q;
    assign o_busy    = (state_q != ST_STOP);
    assign o_pkt_cnt = cnt_q;

endmodule
